// File: rtl/bist_pkg.sv
// ---------------------------------------------------------------------------
// bist_pkg : shared types and constants for the logic-BIST response analyzer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package bist_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPACT = 2'd1,
    S_COMPARE = 2'd2,
    S_DONE    = 2'd3
  } ora_state_e;

  localparam logic [15:0] DEFAULT_POLY = 16'h1021;
  localparam int          WDOG_W       = 16;

endpackage

`default_nettype wire

// File: rtl/bist_misr.sv
// ---------------------------------------------------------------------------
// bist_misr : multiple-input signature register with sync clear, async reset
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bist_misr #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(16'h1021),
  parameter logic [WIDTH-1:0] SEED  = '0
) (
  input  logic             clk,
  input  logic             RST_N,
  input  logic             CLR,
  input  logic             EN,
  input  logic [WIDTH-1:0] DIN,
  output logic [WIDTH-1:0] SIG
);

  logic [WIDTH-1:0] sig_q;
  logic [WIDTH-1:0] sig_d;

  assign sig_d = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ DIN;

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      sig_q <= SEED;
    end else if (CLR) begin
      sig_q <= SEED;
    end else if (EN) begin
      sig_q <= sig_d;
    end
  end

  assign SIG = sig_q;

endmodule

`default_nettype wire

// File: rtl/bist_ora.sv
// ---------------------------------------------------------------------------
// bist_ora : BIST output response analyzer (MISR compaction + golden compare)
// Optional watchdog enabled by defining BIST_ORA_TIMEOUT_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bist_ora
  import bist_pkg::*;
#(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] POLY         = WIDTH'(DEFAULT_POLY),
  parameter logic [WIDTH-1:0] SEED         = '0,
  parameter logic [WIDTH-1:0] GOLDEN_SIG   = '0,
  parameter int               CNT_W        = 16,
  parameter logic [CNT_W-1:0] EXP_PATTERNS = '0,
  parameter int               TIMEOUT_CYC  = 1024
) (
  input  logic             clk,
  input  logic             RST_N,
  input  logic             CLR,
  input  logic             RSP_VALID,
  input  logic [WIDTH-1:0] RSP_DATA,
  input  logic             TPG_END,
  output logic             ORA_RES,
  output logic             PASS,
  output logic [WIDTH-1:0] SIGNATURE,
  output logic [CNT_W-1:0] PAT_CNT
`ifdef BIST_ORA_TIMEOUT_EN
  ,
  output logic             TIMEOUT
`endif
);

  ora_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pass_q, pass_d;
  logic             res_q, res_d;
  logic [WIDTH-1:0] sig;
  logic             accept;
  logic             wdog_hit;

  assign accept = RSP_VALID && ((state_q == S_IDLE) || (state_q == S_COMPACT));

  bist_misr #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clk   (clk),
    .RST_N (RST_N),
    .CLR   (CLR),
    .EN    (accept),
    .DIN   (RSP_DATA),
    .SIG   (sig)
  );

`ifdef BIST_ORA_TIMEOUT_EN
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              to_q, to_d;

  assign wdog_hit = (state_q == S_COMPACT) && (wdog_q == WDOG_W'(TIMEOUT_CYC - 1));
`else
  logic unused_cfg;

  assign wdog_hit   = 1'b0;
  assign unused_cfg = (TIMEOUT_CYC > WDOG_W);
`endif

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (TPG_END)        state_d = S_COMPARE;
        else if (RSP_VALID) state_d = S_COMPACT;
      end
      S_COMPACT: begin
        if (TPG_END)        state_d = S_COMPARE;
        else if (wdog_hit)  state_d = S_DONE;
      end
      S_COMPARE: state_d = S_DONE;
      S_DONE:    state_d = S_DONE;
      default:   state_d = S_IDLE;
    endcase
    if (CLR) state_d = S_IDLE;
  end

  always_comb begin
    res_d  = 1'b0;
    pass_d = pass_q;
    cnt_d  = cnt_q;
    if (accept && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
    if (state_q == S_COMPARE) begin
      res_d  = 1'b1;
      pass_d = (sig == GOLDEN_SIG) && ((EXP_PATTERNS == '0) || (cnt_q == EXP_PATTERNS));
    end
    // TPG_END outranks the watchdog because wdog_hit only wins when no end is seen
    if (wdog_hit && !TPG_END) begin
      res_d  = 1'b1;
      pass_d = 1'b0;
    end
    if (CLR) begin
      res_d  = 1'b0;
      pass_d = 1'b0;
      cnt_d  = '0;
    end
  end

`ifdef BIST_ORA_TIMEOUT_EN
  always_comb begin
    wdog_d = (state_q == S_COMPACT) ? wdog_q + 1'b1 : '0;
    to_d   = to_q || (wdog_hit && !TPG_END);
    if (CLR) begin
      wdog_d = '0;
      to_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      wdog_q <= '0;
      to_q   <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      to_q   <= to_d;
    end
  end

  assign TIMEOUT = to_q;
`endif

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q  <= '0;
      pass_q <= 1'b0;
      res_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pass_q <= pass_d;
      res_q  <= res_d;
    end
  end

  assign ORA_RES   = res_q;
  assign PASS      = pass_q;
  assign SIGNATURE = sig;
  assign PAT_CNT   = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_bist_ora.sv
// ---------------------------------------------------------------------------
// tb_bist_ora : directed + randomized self-checking bench for bist_ora
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bist_ora;

  logic       clk = 1'b0;
  logic       rst_n, clr, v, te;
  logic [7:0] d;

  logic        res2, pass2, res3, pass3;
  logic [7:0]  sig2, sig3;
  logic [15:0] cnt2, cnt3;
`ifdef BIST_ORA_TIMEOUT_EN
  logic        to2, to3;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bist_ora #(
    .WIDTH(8), .POLY(8'h1D), .SEED(8'h00), .GOLDEN_SIG(8'h1C),
    .CNT_W(16), .EXP_PATTERNS(16'd2), .TIMEOUT_CYC(16)
  ) dut2 (
    .clk(clk), .RST_N(rst_n), .CLR(clr), .RSP_VALID(v), .RSP_DATA(d),
    .TPG_END(te), .ORA_RES(res2), .PASS(pass2), .SIGNATURE(sig2), .PAT_CNT(cnt2)
`ifdef BIST_ORA_TIMEOUT_EN
    , .TIMEOUT(to2)
`endif
  );

  bist_ora #(
    .WIDTH(8), .POLY(8'h1D), .SEED(8'h00), .GOLDEN_SIG(8'h1C),
    .CNT_W(16), .EXP_PATTERNS(16'd3), .TIMEOUT_CYC(16)
  ) dut3 (
    .clk(clk), .RST_N(rst_n), .CLR(clr), .RSP_VALID(v), .RSP_DATA(d),
    .TPG_END(te), .ORA_RES(res3), .PASS(pass3), .SIGNATURE(sig3), .PAT_CNT(cnt3)
`ifdef BIST_ORA_TIMEOUT_EN
    , .TIMEOUT(to3)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: signature as polynomial division state over GF(2), x^8 = 1D
  function automatic logic [7:0] model_sig(input logic [7:0] rsp[$]);
    int acc = 0;
    foreach (rsp[i]) begin
      acc = acc * 2;
      if (acc >= 256) acc = (acc - 256) ^ 'h1D;
      acc = acc ^ rsp[i];
    end
    return acc[7:0];
  endfunction

  task automatic idle_inputs();
    v = 1'b0; te = 1'b0; clr = 1'b0; d = 8'h00;
  endtask

  task automatic do_clear(input string tag);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk({tag, "_sig"}, sig2, 8'h00);
    chk({tag, "_cnt"}, cnt2, 0);
    chk({tag, "_pass"}, pass2, 0);
    chk({tag, "_res"}, res2, 0);
  endtask

  // Feeds a run; merge puts TPG_END on the last response.  Checks verdict timing.
  task automatic do_run(input string tag, input logic [7:0] rsp[$], input bit merge);
    logic [7:0] part[$];
    logic [7:0] exp_sig;
    int         n;
    n = rsp.size();
    foreach (rsp[i]) begin
      v = 1'b1; d = rsp[i]; te = merge && (i == n - 1);
      tick();
      part.push_back(rsp[i]);
      chk({tag, "_sig_step"}, sig2, model_sig(part));
    end
    if (!merge) begin
      v = 1'b0; te = 1'b1;
      tick();
    end
    v = 1'b0; te = 1'b0;
    exp_sig = model_sig(rsp);
    chk({tag, "_res_t"}, res2, 0);
    tick();
    chk({tag, "_res_t1"}, res2, 1);
    chk({tag, "_res3_t1"}, res3, 1);
    chk({tag, "_cnt"}, cnt2, n);
    chk({tag, "_sig"}, sig3, exp_sig);
    chk({tag, "_pass2"}, pass2, (exp_sig == 8'h1C) && (n == 2));
    chk({tag, "_pass3"}, pass3, (exp_sig == 8'h1C) && (n == 3));
  endtask

  task automatic finish_done(input string tag, input logic exp_pass);
    tick();
    chk({tag, "_res_t2"}, res2, 0);
    v = 1'b1; te = 1'b1; d = 8'hA5;
    repeat (3) begin
      tick();
      chk({tag, "_no_restrobe"}, res2, 0);
    end
    idle_inputs();
    chk({tag, "_pass_hold"}, pass2, exp_pass);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] e;
    int         n;
    bit         merge;
    bit         seen;

    idle_inputs();
    rst_n = 1'b0;
    tick();
    chk("rst_sig", sig2, 8'h00);
    chk("rst_cnt", cnt2, 0);
    chk("rst_pass", pass2, 0);
    chk("rst_res", res2, 0);
`ifdef BIST_ORA_TIMEOUT_EN
    chk("rst_to", to2, 0);
`endif
    rst_n = 1'b1;
    tick();

    q = '{8'h80, 8'h01};
    do_run("golden", q, 1'b0);
    chk("golden_sig_abs", sig2, 8'h1C);
    finish_done("golden", 1'b1);
    do_clear("clr_golden");

    q = '{8'h80, 8'h03};
    do_run("corrupt", q, 1'b0);
    chk("corrupt_sig_abs", sig2, 8'h1E);
    finish_done("corrupt", 1'b0);
    do_clear("clr_corrupt");

    q = '{8'h80, 8'h01, 8'h05};
    do_run("merge", q, 1'b1);
    chk("merge_cnt3", cnt3, 3);
    chk("merge_sig_abs", sig3, 8'h3D);
    finish_done("merge", 1'b0);
    do_clear("clr_merge");

    v = 1'b1; d = 8'h42;
    tick();
    v = 1'b0;
    chk("mid_sig", sig2, 8'h42);
    do_clear("clr_mid");

    q = '{8'h80, 8'h01};
    do_run("clrres", q, 1'b0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clrres_res", res2, 0);
    chk("clrres_pass", pass2, 0);
    chk("clrres_sig", sig2, 8'h00);
    chk("clrres_cnt", cnt2, 0);
    repeat (3) begin
      tick();
      chk("clrres_no_strobe", res2, 0);
    end
    v = 1'b1; d = 8'h37;
    tick();
    v = 1'b0;
    chk("clrres_idle_accept", sig2, 8'h37);
    chk("clrres_idle_cnt", cnt2, 1);
    do_clear("clr_after");

    v = 1'b1; d = 8'h81;
    tick();
    d = 8'h7E;
    tick();
    v = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_sig", sig2, 8'h00);
    chk("arst_cnt", cnt2, 0);
    chk("arst_pass", pass2, 0);
    chk("arst_res", res2, 0);
    tick();
    rst_n = 1'b1;
    tick();

    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 10);
      merge = ($urandom_range(0, 1) == 1);
      q = {};
      for (int k = 0; k < n; k++) begin
        e = 8'($urandom);
        q.push_back(e);
      end
      do_run("rand", q, merge);
      finish_done("rand", (model_sig(q) == 8'h1C) && (n == 2));
      do_clear("clr_rand");
    end

`ifdef BIST_ORA_TIMEOUT_EN
    v = 1'b1; d = 8'h11;
    tick();
    v = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      tick();
      n++;
      if (res2 === 1'b1) seen = 1'b1;
    end
    chk("wdog_seen", seen, 1);
    chk("wdog_cycles", n, 16);
    chk("wdog_to", to2, 1);
    chk("wdog_pass", pass2, 0);
    tick();
    chk("wdog_res_drop", res2, 0);
    chk("wdog_to_hold", to2, 1);
    do_clear("clr_wdog");
    chk("wdog_to_clr", to2, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bist_ora.md
# bist_ora

Output response analyzer for the logic BIST loop. Compacts circuit-under-test responses into a multiple-input signature register (MISR) while the test pattern generator runs. When the generator signals end of sequence, compares the signature and pattern count against golden values and reports a one-cycle `ORA_RES` verdict strobe to the BIST controller.

## Interface
- `WIDTH`, 16: response and signature width; must be ≥ 2.
- `POLY`, 16'h1021: MISR feedback taps, `WIDTH` bits; bit i set means feed back into bit i.
- `SEED`, 0: signature value after reset or `CLR`.
- `GOLDEN_SIG`, 0: expected final signature.
- `EXP_PATTERNS`, 0: expected compacted-response count; 0 disables the count check.
- `CNT_W`, 16: pattern counter width.
- `TIMEOUT_CYC`, 1024: watchdog limit in cycles; used only with `BIST_ORA_TIMEOUT_EN`.
- `clk`  in  1  system clock, rising edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `CLR`  in  1  synchronous clear; the controller drives it with `TPG_RESET`.
- `RSP_VALID`  in  1  `RSP_DATA` holds a valid CUT response this cycle.
- `RSP_DATA`  in  WIDTH  CUT response word.
- `TPG_END`  in  1  generator has issued its last pattern.
- `ORA_RES`  out  1  one-cycle verdict-ready strobe.
- `PASS`  out  1  held verdict; 1 = pass.
- `SIGNATURE`  out  WIDTH  current MISR contents.
- `PAT_CNT`  out  CNT_W  number of responses compacted.
- `TIMEOUT`  out  1  watchdog expired; this port exists only with `BIST_ORA_TIMEOUT_EN`.

## Operation
- States: IDLE, COMPACT, COMPARE, DONE.
- Reset values: state IDLE, `SIGNATURE` = `SEED`, `PAT_CNT` = 0, `PASS` = 0, `ORA_RES` = 0, `TIMEOUT` = 0.
- MISR update on an accepted `RSP_VALID`:
  - sig_next = {sig[WIDTH-2:0], 0} ^ (sig[WIDTH-1] ? `POLY` : 0) ^ `RSP_DATA`.
  - `PAT_CNT` increments on the same edge and saturates at all-ones; it never wraps.
- IDLE:
  - `RSP_VALID` compacts the response and moves to COMPACT.
  - `TPG_END` moves to COMPARE. This covers an empty run.
- COMPACT:
  - `RSP_VALID` compacts.
  - `TPG_END` moves to COMPARE.
  - If `RSP_VALID` and `TPG_END` are high in the same cycle, that response is compacted before the compare.
- COMPARE: lasts one cycle, then moves to DONE.
  - `PASS` is set to (sig == `GOLDEN_SIG`) && (`EXP_PATTERNS` == 0 || `PAT_CNT` == `EXP_PATTERNS`).
  - `ORA_RES` is set to 1 on the same edge.
  - `RSP_VALID` is ignored.
- DONE:
  - `ORA_RES` returns to 0 after one cycle.
  - `PASS`, `SIGNATURE` and `PAT_CNT` hold.
  - `RSP_VALID` and `TPG_END` are ignored.
- `CLR` has priority over every state and input. It restores the reset values on the next edge, including in mid-compaction or while `ORA_RES` is high.
- `RST_N` low clears everything immediately, independent of `clk`.

## Timing
- MISR and `PAT_CNT` update on the edge that samples `RSP_VALID`; the new value is visible the following cycle.
- Verdict latency:
  - `TPG_END` sampled at edge t: the state is COMPARE after edge t.
  - `ORA_RES` and `PASS` are registered at edge t+1.
  - `ORA_RES` is high for exactly the one cycle between edges t+1 and t+2.
- `ORA_RES` fires exactly once per run. Further `TPG_END` pulses in DONE produce no strobe.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `BIST_ORA_TIMEOUT_EN` defined:
  - A watchdog counts cycles spent in COMPACT and resets on leaving COMPACT.
  - When the count reaches `TIMEOUT_CYC` before `TPG_END`, the block goes straight to DONE and registers `PASS` = 0, `TIMEOUT` = 1 and a single `ORA_RES` pulse.
  - If `TPG_END` arrives on the same cycle the limit is reached, `TPG_END` wins: normal compare, and `TIMEOUT` stays 0.
- Undefined: no watchdog logic, no `TIMEOUT` port, and the block waits in COMPACT indefinitely.

## Structure
- Shared package `bist_pkg`: the ORA state enum, the default `POLY` constant and the watchdog counter width constant.
- One sub-module, `bist_misr`: parameterised by `WIDTH`, `POLY` and `SEED`, with inputs clk, RST_N, CLR, EN and DIN, and output SIG.
- FSM, counter, compare and watchdog live in `bist_ora`.

## Test plan
All scenarios use `WIDTH` = 8, `POLY` = 8'h1D, `SEED` = 0.
- Golden pass:
  - Stimulus: responses 8'h80 then 8'h01, then `TPG_END`; `GOLDEN_SIG` = 8'h1C, `EXP_PATTERNS` = 2.
  - Response: `SIGNATURE` reads 8'h80, then 8'h1C; `PASS` = 1; a single `ORA_RES` pulse 2 edges after `TPG_END`.
- Corrupted response:
  - Stimulus: same run, but the second response is 8'h03.
  - Response: `SIGNATURE` = 8'h1E; `PASS` = 0; `ORA_RES` still pulses once.
- Count mismatch and simultaneous events:
  - Stimulus: `EXP_PATTERNS` = 3, with `RSP_VALID` and `TPG_END` asserted in the same cycle on the third response.
  - Response: `PAT_CNT` = 3 and that response is included in the signature. `PASS` = 0 when the final signature ≠ `GOLDEN_SIG` (the count matches).
- Clear mid-run and after the verdict:
  - Stimulus: `CLR` after 1 response; separately, `CLR` in the same cycle `ORA_RES` is high.
  - Response: `SIGNATURE` = 8'h00, `PAT_CNT` = 0 and state IDLE one edge later; `PASS` = 0; no extra strobe.
- Asynchronous reset:
  - Stimulus: `RST_N` low mid-edge-interval during COMPACT.
  - Response: all outputs go to reset values before the next `clk` edge.
- Watchdog (`BIST_ORA_TIMEOUT_EN`, `TIMEOUT_CYC` = 16):
  - Stimulus: enter COMPACT, then withhold `TPG_END`.
  - Response: at 16 cycles, `TIMEOUT` = 1, `PASS` = 0 and one `ORA_RES` pulse.
